// File: rtl/db_pkg.sv
// Shared types and the per-channel debounce transition function for the
// time-multiplexed switch debouncer.
package db_pkg;

   typedef enum logic [2:0] {
      ZERO    = 3'd0,
      WAIT1_1 = 3'd1,
      WAIT1_2 = 3'd2,
      ONE     = 3'd3,
      WAIT0_1 = 3'd4,
      WAIT0_2 = 3'd5
   } db_state_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } ctrl_t;

   // Three agreeing samples are needed to cross between the stable states;
   // any disagreeing sample drops straight back to the stable state.
   function automatic db_state_t db_next(input db_state_t cur, input logic s);
      db_state_t nxt;
      case (cur)
         ZERO:    nxt = s ? WAIT1_1 : ZERO;
         WAIT1_1: nxt = s ? WAIT1_2 : ZERO;
         WAIT1_2: nxt = s ? ONE     : ZERO;
         ONE:     nxt = s ? ONE     : WAIT0_1;
         WAIT0_1: nxt = s ? ONE     : WAIT0_2;
         WAIT0_2: nxt = s ? ONE     : ZERO;
         default: nxt = ZERO;
      endcase
      return nxt;
   endfunction

   function automatic logic db_is_high(input db_state_t cur);
      return (cur == ONE) || (cur == WAIT0_1) || (cur == WAIT0_2);
   endfunction

endpackage

// File: rtl/db_tick_gen.sv
// Free-running sample tick: one-cycle pulse every CLK_FREQ/TICK_HZ clocks.
module db_tick_gen #(
   parameter int CLK_FREQ = 200_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
   localparam int CW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(TICK_CYC - 1));
   assign tick   = w_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/db_sw_sched.sv
// Debouncer for N_SW switches sharing one tick generator and one next-state
// evaluator; a sweep visits each channel once per tick, one channel per clock.
module db_sw_sched
   import db_pkg::*;
#(
   parameter int CLK_FREQ = 200_000_000,
   parameter int TICK_HZ  = 100,
   parameter int N_SW     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw,
   output logic [N_SW-1:0] db,
   output logic [N_SW-1:0] db_rise,
   output logic [N_SW-1:0] db_fall,
   output logic            tick
);

   localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
   localparam int IW       = (N_SW > 1) ? $clog2(N_SW) : 1;

   // A sweep must finish before the next tick, so a tick never lands mid-sweep.
   if (N_SW < 1 || N_SW >= TICK_CYC) begin : g_paramCheck
      $error("db_sw_sched: N_SW must satisfy 1 <= N_SW < CLK_FREQ/TICK_HZ");
   end

   logic [N_SW-1:0] r_swMeta;
   logic [N_SW-1:0] r_swSync;
   ctrl_t           r_ctrl;
   ctrl_t           w_ctrlNext;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   w_idxNext;
   db_state_t       r_state [N_SW];
   db_state_t       w_slotCur;
   db_state_t       w_slotNext;
   logic            w_sample;
   logic            w_update;
   logic            w_tick;
   logic [N_SW-1:0] r_rise;
   logic [N_SW-1:0] r_fall;

   db_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_HZ  (TICK_HZ)
   ) u_tickGen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_swMeta <= '0;
         r_swSync <= '0;
      end else begin
         r_swMeta <= sw;
         r_swSync <= r_swMeta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl <= IDLE;
         r_idx  <= '0;
      end else begin
         r_ctrl <= w_ctrlNext;
         r_idx  <= w_idxNext;
      end
   end

   // Ticks seen while sweeping are ignored rather than restarting the sweep.
   always_comb begin
      w_ctrlNext = r_ctrl;
      w_idxNext  = r_idx;
      w_update   = 1'b0;
      case (r_ctrl)
         IDLE: begin
            if (w_tick) begin
               w_ctrlNext = SWEEP;
               w_idxNext  = '0;
            end
         end
         SWEEP: begin
            w_update = 1'b1;
            if (r_idx == IW'(N_SW - 1)) begin
               w_ctrlNext = IDLE;
               w_idxNext  = '0;
            end else begin
               w_idxNext = r_idx + 1'b1;
            end
         end
         default: begin
            w_ctrlNext = IDLE;
            w_idxNext  = '0;
         end
      endcase
   end

   assign w_slotCur  = r_state[r_idx];
   assign w_sample   = r_swSync[r_idx];
   assign w_slotNext = db_next(w_slotCur, w_sample);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_SW; i++) begin
            r_state[i] <= ZERO;
         end
      end else if (w_update) begin
         r_state[r_idx] <= w_slotNext;
      end
   end

   // Pulses land in the same cycle the decoded level changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_rise <= '0;
         r_fall <= '0;
         if (w_update && (w_slotCur == WAIT1_2) && (w_slotNext == ONE)) begin
            r_rise[r_idx] <= 1'b1;
         end
         if (w_update && (w_slotCur == WAIT0_2) && (w_slotNext == ZERO)) begin
            r_fall[r_idx] <= 1'b1;
         end
      end
   end

   always_comb begin
      db = '0;
      for (int i = 0; i < N_SW; i++) begin
         db[i] = db_is_high(r_state[i]);
      end
   end

   assign db_rise = r_rise;
   assign db_fall = r_fall;
   assign tick    = w_tick;

endmodule

// File: tb/tb_db_sw_sched.sv
// Directed bench for db_sw_sched: TICK_CYC=10, four channels, per-sweep logs
// of pulses and levels compared against hand-worked expectations.
module tb_db_sw_sched;
   import db_pkg::*;

   localparam int CLK_FREQ  = 1000;
   localparam int TICK_HZ   = 100;
   localparam int N_SW      = 4;
   localparam int CLK_HALF  = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_SW-1:0] sw  = 4'hF;
   logic [N_SW-1:0] db;
   logic [N_SW-1:0] db_rise;
   logic [N_SW-1:0] db_fall;
   logic            tick;

   int checks   = 0;
   int failures = 0;

   logic [3:0] riseLog [1:5];
   logic [3:0] fallLog [1:5];
   logic [3:0] dbLog   [1:5];
   logic [3:0] riseAcc;
   logic [3:0] fallAcc;
   logic [3:0] savedAcc;
   int         waitCycles;
   time        tickTime     = 0;
   time        prevTickTime = 0;

   db_sw_sched #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_HZ  (TICK_HZ),
      .N_SW     (N_SW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw),
      .db      (db),
      .db_rise (db_rise),
      .db_fall (db_fall),
      .tick    (tick)
   );

   always #CLK_HALF clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps on negedges until tick is seen, bounded so a dead counter cannot hang.
   task automatic waitTick();
      waitCycles = 0;
      while (tick !== 1'b1 && waitCycles < 40) begin
         @(posedge clk);
         @(negedge clk);
         waitCycles++;
      end
      if (tick !== 1'b1) checkOutput("tickTimeout", 32'(tick), 32'd1);
   endtask

   // After the tick cycle: cycle 1 enters SWEEP, channel k changes in cycle 2+k.
   task automatic runSweep();
      waitTick();
      prevTickTime = tickTime;
      tickTime     = $time;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         riseLog[c] = db_rise;
         fallLog[c] = db_fall;
         dbLog[c]   = db;
         riseAcc    = riseAcc | db_rise;
         fallAcc    = fallAcc | db_fall;
         if (c <= 4) checkOutput("noTickInSweep", 32'(tick), 32'd0);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] swVal, input int nSweeps);
      sw      = swVal;
      riseAcc = '0;
      fallAcc = '0;
      repeat (nSweeps) runSweep();
   endtask

   initial begin
      // 1: reset with all switches pressed
      sw  = 4'hF;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("rstDb",   32'(db),      32'h0);
         checkOutput("rstRise", 32'(db_rise), 32'h0);
         checkOutput("rstFall", 32'(db_fall), 32'h0);
         checkOutput("rstTick", 32'(tick),    32'h0);
      end
      rst = 1'b0;

      // 2: channel 2 held high; tick appears when cnt reaches 9
      applyStimulus(4'b0100, 1);
      checkOutput("firstTickDelay", 32'(waitCycles), 32'd9);
      checkOutput("t2Sweep1Db", 32'(dbLog[5]), 32'h0);
      applyStimulus(4'b0100, 1);
      checkOutput("tickPeriod", 32'(tickTime - prevTickTime), 32'(20 * CLK_HALF));
      checkOutput("t2Sweep2Db", 32'(dbLog[5]), 32'h0);
      applyStimulus(4'b0100, 1);
      checkOutput("t2DbBeforeSlot", 32'(dbLog[3]), 32'h0);
      checkOutput("t2RiseSlot2", 32'(riseLog[4]), 32'h4);
      checkOutput("t2DbAtSlot2", 32'(dbLog[4]), 32'h4);
      checkOutput("t2RiseSingle", 32'(riseLog[1] | riseLog[2] | riseLog[3] | riseLog[5]), 32'h0);
      checkOutput("t2NoFall", 32'(fallAcc), 32'h0);

      // 3: channel 1 bounces after two agreeing sweeps
      applyStimulus(4'b0110, 2);
      savedAcc = riseAcc;
      checkOutput("t3State1Wait", 32'(dut.r_state[1]), 32'(WAIT1_2));
      checkOutput("t3DbStill", 32'(dbLog[5]), 32'h4);
      applyStimulus(4'b0100, 1);
      checkOutput("t3State1Zero", 32'(dut.r_state[1]), 32'(ZERO));
      checkOutput("t3NoRise", 32'(savedAcc | riseAcc), 32'h0);
      checkOutput("t3Db", 32'(dbLog[5]), 32'h4);

      // 4: channel 0 pressed, short release glitch, then real release
      applyStimulus(4'b0101, 3);
      checkOutput("t4Rise0", 32'(riseLog[2]), 32'h1);
      checkOutput("t4DbPressed", 32'(dbLog[5]), 32'h5);
      applyStimulus(4'b0100, 2);
      checkOutput("t4GlitchDb", 32'(dbLog[5]), 32'h5);
      checkOutput("t4GlitchNoFall", 32'(fallAcc), 32'h0);
      applyStimulus(4'b0101, 1);
      checkOutput("t4RecoverState", 32'(dut.r_state[0]), 32'(ONE));
      checkOutput("t4RecoverNoFall", 32'(fallAcc), 32'h0);
      applyStimulus(4'b0100, 3);
      checkOutput("t4DbBeforeFall", 32'(dbLog[1]), 32'h5);
      checkOutput("t4Fall0", 32'(fallLog[2]), 32'h1);
      checkOutput("t4DbReleased", 32'(dbLog[2]), 32'h4);
      checkOutput("t4NoRise", 32'(riseAcc), 32'h0);

      // 5: clear channel 2, then press everything at once
      applyStimulus(4'b0000, 3);
      checkOutput("t5Fall2", 32'(fallLog[4]), 32'h4);
      checkOutput("t5DbClear", 32'(dbLog[5]), 32'h0);
      applyStimulus(4'b1111, 3);
      checkOutput("t5RiseCh0", 32'(riseLog[2]), 32'h1);
      checkOutput("t5RiseCh1", 32'(riseLog[3]), 32'h2);
      checkOutput("t5RiseCh2", 32'(riseLog[4]), 32'h4);
      checkOutput("t5RiseCh3", 32'(riseLog[5]), 32'h8);
      applyStimulus(4'b1111, 1);
      checkOutput("t5DbAll", 32'(dbLog[5]), 32'hF);
      checkOutput("t5NoMoreRise", 32'(riseAcc), 32'h0);

      // 6: reach db=A, then reset in the middle of a sweep
      applyStimulus(4'b1010, 3);
      checkOutput("t6DbA", 32'(dbLog[5]), 32'hA);
      checkOutput("t6Falls", 32'(fallLog[2] | fallLog[4]), 32'h5);
      waitTick();
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("t6MidSweepCtrl", 32'(dut.r_ctrl), 32'(SWEEP));
      checkOutput("t6MidSweepIdx", 32'(dut.r_idx), 32'd1);
      checkOutput("t6MidSweepDb", 32'(db), 32'hA);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("t6RstDb",   32'(db),                 32'h0);
         checkOutput("t6RstCtrl", 32'(dut.r_ctrl),         32'(IDLE));
         checkOutput("t6RstIdx",  32'(dut.r_idx),          32'd0);
         checkOutput("t6RstCnt",  32'(dut.u_tickGen.r_cnt), 32'd0);
         checkOutput("t6RstPulse", 32'(db_rise | db_fall), 32'h0);
         checkOutput("t6RstTick", 32'(tick),               32'h0);
      end
      checkOutput("t6RstState3", 32'(dut.r_state[3]), 32'(ZERO));
      rst     = 1'b0;
      riseAcc = '0;
      fallAcc = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         riseAcc = riseAcc | db_rise;
         fallAcc = fallAcc | db_fall;
      end
      checkOutput("t6PostRstPulses", 32'(riseAcc | fallAcc), 32'h0);
      checkOutput("t6PostRstDb", 32'(db), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
